// File: rtl/regfile.sv
// Multi-ported register file: two combinational read ports, one synchronous write port,
// asynchronous active-low clear of every register.
module regfile #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_port_1,
    input  logic [ADDR_WIDTH-1:0] read_port_2,
    input  logic [ADDR_WIDTH-1:0] write_port_1,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2
);

    // Every address must decode to a real register, so no range checks are needed.
    if (NUM_REGS != (2 ** ADDR_WIDTH)) begin : gen_bad_params
        $error("regfile: NUM_REGS must equal 2**ADDR_WIDTH");
    end

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (write_enable) begin
            regs_d[write_port_1] = write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads come straight from the storage: old value before the edge, new after it.
    assign read_data_1 = regs_q[read_port_1];
    assign read_data_2 = regs_q[read_port_2];

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: per-cycle comparison against an array model plus
// directed vectors with hand-computed expectations.
module tb_regfile;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] read_port_1 = '0;
    logic [2:0] read_port_2 = '0;
    logic [2:0] write_port_1 = '0;
    logic [7:0] write_data = '0;
    logic       write_enable = 1'b0;
    logic [7:0] read_data_1;
    logic [7:0] read_data_2;

    int checks = 0;
    int passed = 0;
    bit run_model = 1'b0;

    logic [7:0] model [8];

    regfile #(
        .DATA_WIDTH(8),
        .NUM_REGS  (8),
        .ADDR_WIDTH(3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .read_port_1 (read_port_1),
        .read_port_2 (read_port_2),
        .write_port_1(write_port_1),
        .write_data  (write_data),
        .write_enable(write_enable),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%02h, required 0x%02h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a plain array of eight bytes, cleared by reset, written on enabled edges.
    initial begin
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) model[i] = 8'h00;
        end else if (write_enable) begin
            model[write_port_1] = write_data;
        end
    end

    always @(negedge clk) begin
        if (run_model) begin
            check("model_rd1", read_data_1, model[read_port_1]);
            check("model_rd2", read_data_2, model[read_port_2]);
        end
    end

    // Leaves write_enable high so back-to-back calls write on consecutive edges.
    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        #1;
        write_enable = 1'b1;
        write_port_1 = a;
        write_data   = d;
    endtask

    task automatic idle();
        @(negedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        check("reset_rd1", read_data_1, 8'h00);
        check("reset_rd2", read_data_2, 8'h00);
        #9;
        rst_n = 1'b1;
        run_model = 1'b1;

        // Two consecutive writes, then read back both
        wr(3'd7, 8'h24);
        wr(3'd4, 8'h81);
        idle();
        read_port_1 = 3'd7;
        read_port_2 = 3'd4;
        #1;
        check("wr7_rd1", read_data_1, 8'h24);
        check("wr4_rd2", read_data_2, 8'h81);

        // Disabled write must not disturb reg4
        write_port_1 = 3'd4;
        write_data   = 8'hFF;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("we0_hold", read_data_2, 8'h81);

        // No bypass: old value before the edge, new value after it
        @(negedge clk);
        #1;
        read_port_1  = 3'd2;
        write_port_1 = 3'd2;
        write_data   = 8'h09;
        write_enable = 1'b1;
        #1;
        check("nobypass_old", read_data_1, 8'h00);
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        check("nobypass_new", read_data_1, 8'h09);

        // Both ports on the same register
        read_port_1 = 3'd7;
        read_port_2 = 3'd7;
        #1;
        check("same_rd1", read_data_1, 8'h24);
        check("same_rd2", read_data_2, 8'h24);

        // Asynchronous reset between edges; a write during reset is dropped
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rd1", read_data_1, 8'h00);
        check("async_rst_rd2", read_data_2, 8'h00);
        write_enable = 1'b1;
        write_port_1 = 3'd3;
        write_data   = 8'hAA;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        read_port_1 = 3'd3;
        #1;
        check("rst_write_lost", read_data_1, 8'h00);

        // First edge after reset release accepts a write
        write_enable = 1'b1;
        write_port_1 = 3'd5;
        write_data   = 8'h5A;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        read_port_2 = 3'd5;
        #1;
        check("first_write", read_data_2, 8'h5A);

        // Distinct value in every register, then sweep both ports
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 8'(8'h10 + i));
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp1;
            logic [7:0] exp2;
            exp1 = 8'(8'h10 + i);
            exp2 = 8'(8'h17 - i);
            read_port_1 = 3'(i);
            read_port_2 = 3'(7 - i);
            #1;
            check("sweep_rd1", read_data_1, exp1);
            check("sweep_rd2", read_data_2, exp2);
        end

        @(negedge clk);
        #1;
        run_model = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001: Parameter DATA_WIDTH, default 8, SHALL set the width of each register and of all data ports.
REQ-002: Parameter NUM_REGS, default 8, SHALL set the number of registers.
REQ-003: Parameter ADDR_WIDTH, default 3, SHALL set the width of all address ports; NUM_REGS SHALL equal 2**ADDR_WIDTH.
REQ-004: The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005: clk  input  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-006: rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007: read_port_1  input  ADDR_WIDTH  SHALL select the register driven on read_data_1.
REQ-008: read_port_2  input  ADDR_WIDTH  SHALL select the register driven on read_data_2.
REQ-009: write_port_1  input  ADDR_WIDTH  SHALL select the register to write.
REQ-010: write_data  input  DATA_WIDTH  SHALL carry the value to write.
REQ-011: write_enable  input  1  SHALL enable the write when high.
REQ-012: read_data_1  output  DATA_WIDTH  SHALL carry the contents of register[read_port_1].
REQ-013: read_data_2  output  DATA_WIDTH  SHALL carry the contents of register[read_port_2].
REQ-014: Port order SHALL be clk, rst_n, read_port_1, read_port_2, write_port_1, write_data, write_enable, read_data_1, read_data_2.

Function
REQ-015: The storage SHALL be NUM_REGS registers of DATA_WIDTH bits, addressed 0..NUM_REGS-1.
REQ-016: All registers, including register 0, SHALL be writable and hold ordinary values; register 0 SHALL NOT be hardwired to zero.
REQ-017: On a rising clk edge with write_enable=1 and rst_n=1, register[write_port_1] SHALL load write_data.
REQ-018: With write_enable=0, no register SHALL change.
REQ-019: Registers not addressed by write_port_1 SHALL hold their values.
REQ-020: Reads SHALL be combinational, with zero-cycle latency: read_data_N SHALL follow changes to read_port_N and to register contents within the same cycle.
REQ-021: Both read ports SHALL operate independently and MAY address the same register at the same time, each returning the same value.
REQ-022: When a read address equals write_port_1 during a write cycle, the read port SHALL return the old value before the edge and the new value after it; there SHALL be no write-to-read bypass.
REQ-023: Write data SHALL be stored exactly at DATA_WIDTH bits, with no sign extension and no arithmetic applied.
REQ-024: Address inputs SHALL always be in range because NUM_REGS = 2**ADDR_WIDTH; no out-of-range handling is required.
REQ-025: X or Z on write_enable SHALL NOT be relied upon; the bench SHALL drive it to a known level at all times.

Reset
REQ-026: rst_n=0 SHALL clear every register to 0 immediately, without waiting for a clock edge.
REQ-027: While rst_n=0, read_data_1 and read_data_2 SHALL read 0 and writes SHALL be ignored.
REQ-028: If reset asserts in the middle of a write cycle, reset SHALL take priority and the write SHALL be lost.
REQ-029: The first write SHALL be accepted on the first rising clk edge after rst_n deasserts.

Verification
REQ-030: Reset, then write 0x24 to reg7 and 0x81 to reg4 on consecutive edges; set write_enable=0, read_port_1=7, read_port_2=4 -> read_data_1=0x24, read_data_2=0x81.
REQ-031: With write_enable=0 and write_port_1=4, drive write_data=0xFF for 2 edges -> reg4 still reads 0x81.
REQ-032: Set read_port_1=2 and write 0x09 to reg2 -> read_data_1 shows the old value 0x00 before the edge and 0x09 immediately after it.
REQ-033: Set read_port_1=read_port_2=7 -> both read ports show 0x24.
REQ-034: Assert rst_n=0 between clock edges -> both read ports go to 0x00 at once; a write attempted during reset is not stored.
REQ-035: Write a distinct value (0x10+i) to every register 0..7, then sweep both read ports -> every register returns its own value.
